register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-port integer register file for the decode/writeback boundary: NRD combinational read ports, NWR synchronous write ports, XLEN-wide entries, DEPTH entries.
- Adds an in-flight scoreboard: one busy bit per entry, set at issue and cleared at writeback.
- Each read port reports readiness so decode can stall on RAW hazards. Entry 0 is hardwired zero.

Parameters:
- XLEN, 32, entry width in bits.
- DEPTH, 32, number of entries (power of two, at least 2); AW = log2(DEPTH).
- NRD, 2, read port count (1..4).
- NWR, 1, write port count (1..2); higher port index has priority.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low.
- rden  input  NRD  per-port read enable.
- raddr  input  NRD*AW  read addresses, port i at bits [i*AW +: AW].
- rdata  output  NRD*XLEN  read data.
- rrdy  output  NRD  per-port operand ready (no RAW hazard).
- wren  input  NWR  per-port write enable.
- waddr  input  NWR*AW  write addresses.
- wdata  input  NWR*XLEN  write data.
- iss_en  input  1  issue: mark iss_addr busy.
- iss_addr  input  AW  destination register of the issuing instruction.
- busy_cnt  output  AW+1  number of entries currently busy.

Behaviour:
- Reset (rst=0, asynchronous): all entries go to 0 and all busy bits to 0. While reset is held: rdata=0, rrdy=all 1, busy_cnt=0. Reset asserted mid-operation discards pending writes in the same cycle.
- Read is combinational, 0-cycle latency:
  - rden=0 or raddr=0 -> rdata=0, rrdy=1.
  - Otherwise rdata = stored entry, rrdy = !busy[raddr].
- Write takes effect on the next edge; writes to address 0 are ignored.
  - Two write ports on the same address in the same cycle: the higher port index wins.
- Busy bits:
  - Set on an edge where iss_en=1 and iss_addr!=0.
  - Cleared on an edge where any wren targets that address.
  - Set and clear on the same address in the same edge: set wins (a new producer supersedes the old one).
  - Issue to an already-busy entry keeps it busy; no error.
- busy_cnt is registered and updated on the same edge as the busy bits. It equals the population count of the busy bits after the edge and saturates logically at DEPTH-1, since entry 0 is never busy.
- A write without a preceding issue is legal: data is written, and busy stays 0 (or is cleared).
- Without bypass, a read of an address being written this cycle returns the old value; the new value is visible next cycle.

Optional Feature:
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - If rden=1, raddr!=0 and any wren port targets raddr this cycle, rdata takes that port's wdata (highest index wins) and rrdy=1 regardless of busy.
  - This adds a combinational path wdata->rdata.
- Undefined: no forwarding; behaviour as described above.

Decomposition:
- Package wires holds:
  - register_mp_read_in_type (rden, raddr arrays)
  - register_mp_write_in_type (wren, waddr, wdata arrays)
  - register_mp_issue_in_type (iss_en, iss_addr)
  - register_mp_out_type (rdata, rrdy, busy_cnt)
  - constants REG_XLEN and REG_DEPTH
- The top module may flatten these structures to the ports listed above.
- One sub-module, register_scoreboard, holds the busy bits, set/clear priority and busy_cnt. Storage, read muxing and bypass stay in register_file_mp.

Test Plan:
- Reset then read: hold rst=0 with traffic on all inputs, release -> every port read of addresses 0..31 returns 0 and rrdy=1; busy_cnt=0.
- Basic write/read: write 0xDEADBEEF to r5; next cycle read r5 on both ports -> 0xDEADBEEF on both ports. Write 0x1234 to r0 -> reading r0 returns 0.
- Scoreboard hazard: issue r7 -> next cycle rrdy for r7 is 0 and busy_cnt=1. Write 0xA5 to r7 -> next cycle rrdy=1, rdata=0xA5, busy_cnt=0.
- Simultaneous set/clear: r9 busy; in one cycle issue r9 and write r9=0x55 -> r9 stays busy and holds 0x55, busy_cnt unchanged.
- Write-port priority (NWR=2): port0 writes r3=0x11 and port1 writes r3=0x22 in the same cycle -> r3 reads 0x22.
- Bypass (REGFILE_BYPASS_EN): r4 busy with old value 0x1; in the same cycle write r4=0x99 and read r4 -> rdata=0x99, rrdy=1. Without the macro -> rdata=0x1, rrdy=0.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// register_file_mp_pkg
// Shared types and constants for the multi-port register file with
// in-flight scoreboard. The struct types describe the grouped read, write,
// issue and output buses at the default geometry (REG_XLEN x REG_DEPTH,
// up to four read and two write ports). The top level flattens them to
// plain vector ports.
package register_file_mp_pkg;

    localparam int REG_XLEN    = 32;
    localparam int REG_DEPTH   = 32;
    localparam int REG_AW      = $clog2(REG_DEPTH);
    localparam int REG_NRD_MAX = 4;
    localparam int REG_NWR_MAX = 2;

    typedef struct packed {
        logic [REG_NRD_MAX-1:0]             rden;
        logic [REG_NRD_MAX-1:0][REG_AW-1:0] raddr;
    } register_mp_read_in_type;

    typedef struct packed {
        logic [REG_NWR_MAX-1:0]               wren;
        logic [REG_NWR_MAX-1:0][REG_AW-1:0]   waddr;
        logic [REG_NWR_MAX-1:0][REG_XLEN-1:0] wdata;
    } register_mp_write_in_type;

    typedef struct packed {
        logic              iss_en;
        logic [REG_AW-1:0] iss_addr;
    } register_mp_issue_in_type;

    typedef struct packed {
        logic [REG_NRD_MAX-1:0][REG_XLEN-1:0] rdata;
        logic [REG_NRD_MAX-1:0]               rrdy;
        logic [REG_AW:0]                      busy_cnt;
    } register_mp_out_type;

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// register_scoreboard
// One busy bit per register entry: set when an instruction targeting the
// entry issues, cleared when any write port retires to it. Issue beats
// writeback on the same entry in the same edge, because the newly issued
// producer supersedes the one that is retiring. Entry 0 is never busy.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   wren, waddr       write-port enables / addresses (clear sources)
//   iss_en, iss_addr  issue strobe / destination (set source)
//   busy              current busy bits, one per entry
//   busy_cnt          registered population count of busy
module register_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int DEPTH = REG_DEPTH,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wren,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic [DEPTH-1:0]  busy,
    output logic [AW:0]       busy_cnt
);

    logic [DEPTH-1:0] busy_nxt;

    function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NWR; w++) begin
            if (wren[w]) begin
                busy_nxt[waddr[w*AW +: AW]] = 1'b0;
            end
        end
        // Set is applied after clear so it wins on a collision.
        if (iss_en && iss_addr != '0) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // The count is computed from the next-state vector so that it lands on
    // the same edge as the busy bits it describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp
// Multi-port integer register file for the decode/writeback boundary.
// NRD combinational read ports, NWR synchronous write ports (higher port
// index wins on a same-address collision), entry 0 reads as zero and
// ignores writes. A scoreboard tracks in-flight destinations so each read
// port can report whether its operand is ready.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// to matching read ports (adds a combinational wdata->rdata path).
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   rden, raddr       per-port read enable / address (port i at [i*AW +: AW])
//   rdata, rrdy       per-port read data / operand ready
//   wren, waddr, wdata  per-port write enable / address / data
//   iss_en, iss_addr  issue strobe / destination register
//   busy_cnt          number of entries currently busy
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int XLEN  = REG_XLEN,
    parameter int DEPTH = REG_DEPTH,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rden,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rrdy,
    input  logic [NWR-1:0]      wren,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [AW-1:0]    ra;

    register_scoreboard #(
        .DEPTH (DEPTH),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wren     (wren),
        .waddr    (waddr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // Ports are visited in ascending order so the last (highest-index)
    // assignment to a shared address is the one that sticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wren[w] && waddr[w*AW +: AW] != '0) begin
                    mem[waddr[w*AW +: AW]] <= wdata[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Reads are gated with rst so that forwarding cannot leak write-port
    // traffic onto rdata while reset is held.
    always_comb begin
        rdata = '0;
        rrdy  = '1;
        ra    = '0;
        for (int r = 0; r < NRD; r++) begin
            ra = raddr[r*AW +: AW];
            if (rst && rden[r] && ra != '0) begin
                rdata[r*XLEN +: XLEN] = mem[ra];
                rrdy[r]               = ~busy[ra];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NWR; w++) begin
                    if (wren[w] && waddr[w*AW +: AW] == ra) begin
                        rdata[r*XLEN +: XLEN] = wdata[w*XLEN +: XLEN];
                        rrdy[r]               = 1'b1;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD-1:0]      rden;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rrdy;
    logic [NWR-1:0]      wren;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [AW:0]         busy_cnt;

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] data;
        logic        rdy;
        bit          chk_cnt;
        logic [5:0]  cnt;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    register_file_mp #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rden     (rden),
        .raddr    (raddr),
        .rdata    (rdata),
        .rrdy     (rrdy),
        .wren     (wren),
        .waddr    (waddr),
        .wdata    (wdata),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic idle();
        rden = '0; raddr = '0; wren = '0; waddr = '0; wdata = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input int p, input int a, input logic en);
        rden[p] = en;
        raddr[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wren[p] = 1'b1;
        waddr[p*AW +: AW] = a[AW-1:0];
        wdata[p*XLEN +: XLEN] = d;
    endtask

    task automatic iss(input int a);
        iss_en = 1'b1;
        iss_addr = a[AW-1:0];
    endtask

    task automatic push_exp(input string n, input int p, input logic [31:0] d,
                            input logic r, input bit cc, input int c);
        exp_t e;
        e.cyc = cyc; e.port = p; e.data = d; e.rdy = r;
        e.chk_cnt = cc; e.cnt = c[5:0]; e.name = n;
        q.push_back(e);
    endtask

    // Monitor: compares every expectation scheduled for the current cycle,
    // sampling on the falling edge while inputs are stable.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] d;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            d = rdata[e.port*XLEN +: XLEN];
            checks++;
            if (e.cyc != cyc || d !== e.data || rrdy[e.port] !== e.rdy ||
                (e.chk_cnt && busy_cnt !== e.cnt)) begin
                errors++;
                $display("FAIL %s cyc=%0d port=%0d got rdata=%h rrdy=%b cnt=%0d want rdata=%h rrdy=%b cnt=%0d",
                         e.name, e.cyc, e.port, d, rrdy[e.port], busy_cnt,
                         e.data, e.rdy, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        // Traffic on every input while reset is held.
        rden = '1; raddr = {5'd6, 5'd6};
        wren = '1; waddr = {5'd6, 5'd6}; wdata = {32'h1111_2222, 32'h3333_4444};
        iss_en = 1'b1; iss_addr = 5'd6;
        repeat (3) begin
            @(posedge clk); #1;
            push_exp("rst_hold0", 0, 32'h0, 1'b1, 1, 0);
            push_exp("rst_hold1", 1, 32'h0, 1'b1, 0, 0);
        end
        step();
        #2 rst = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            step();
            rd(0, a, 1'b1); rd(1, a, 1'b1);
            push_exp("rst_rd0", 0, 32'h0, 1'b1, 1, 0);
            push_exp("rst_rd1", 1, 32'h0, 1'b1, 0, 0);
        end

        // Basic write/read and r0 hardwiring.
        step(); wr(0, 5, 32'hDEAD_BEEF);
        step(); rd(0, 5, 1'b1); rd(1, 5, 1'b1);
        push_exp("wr_rd0", 0, 32'hDEAD_BEEF, 1'b1, 1, 0);
        push_exp("wr_rd1", 1, 32'hDEAD_BEEF, 1'b1, 0, 0);
        step(); wr(0, 0, 32'h1234); rd(0, 5, 1'b0);
        push_exp("rden_off", 0, 32'h0, 1'b1, 1, 0);
        step(); rd(0, 0, 1'b1);
        push_exp("r0_zero", 0, 32'h0, 1'b1, 1, 0);

        // RAW hazard via scoreboard.
        step(); iss(7);
        step(); rd(0, 7, 1'b1);
        push_exp("haz_busy", 0, 32'h0, 1'b0, 1, 1);
        step(); wr(0, 7, 32'hA5);
        step(); rd(0, 7, 1'b1); rd(1, 7, 1'b1);
        push_exp("haz_clr0", 0, 32'hA5, 1'b1, 1, 0);
        push_exp("haz_clr1", 1, 32'hA5, 1'b1, 0, 0);

        // Simultaneous set and clear: set wins.
        step(); iss(9);
        step(); iss(9); wr(0, 9, 32'h55); rd(0, 0, 1'b1);
        push_exp("setclr_pre", 0, 32'h0, 1'b1, 1, 1);
        step(); rd(0, 9, 1'b1);
        push_exp("setclr", 0, 32'h55, 1'b0, 1, 1);
        step(); wr(1, 9, 32'h66);
        step(); rd(0, 9, 1'b1);
        push_exp("clr_port1", 0, 32'h66, 1'b1, 1, 0);

        // Write-port priority.
        step(); wr(0, 3, 32'h11); wr(1, 3, 32'h22);
        step(); rd(0, 3, 1'b1); rd(1, 3, 1'b1);
        push_exp("wprio0", 0, 32'h22, 1'b1, 1, 0);
        push_exp("wprio1", 1, 32'h22, 1'b1, 0, 0);

        // Same-cycle write and read of a busy entry.
        step(); wr(0, 4, 32'h1);
        step(); iss(4);
        step(); wr(1, 4, 32'h99); rd(0, 4, 1'b1); rd(1, 4, 1'b1);
`ifdef REGFILE_BYPASS_EN
        push_exp("bypass0", 0, 32'h99, 1'b1, 1, 1);
        push_exp("bypass1", 1, 32'h99, 1'b1, 0, 1);
`else
        push_exp("nobypass0", 0, 32'h1, 1'b0, 1, 1);
        push_exp("nobypass1", 1, 32'h1, 1'b0, 0, 1);
`endif
        step(); rd(0, 4, 1'b1);
        push_exp("after_wr4", 0, 32'h99, 1'b1, 1, 0);

        // Several busy entries; issue to r0 is ignored.
        step(); iss(1);
        step(); iss(2);
        step(); iss(0);
        step(); iss(3);
        step(); rd(0, 0, 1'b1); rd(1, 2, 1'b1);
        push_exp("cnt3", 0, 32'h0, 1'b1, 1, 3);
        push_exp("r2_busy", 1, 32'h0, 1'b0, 0, 3);
        step(); iss(2); rd(0, 3, 1'b1);
        push_exp("r3_busy", 0, 32'h22, 1'b0, 1, 3);
        step(); rd(0, 0, 1'b1);
        push_exp("reiss_cnt", 0, 32'h0, 1'b1, 1, 3);

        // Reset asserted mid-cycle with a write pending.
        step(); wr(0, 5, 32'hCAFE_F00D);
        #2 rst = 1'b0;
        rd(0, 3, 1'b1);
        push_exp("midrst_hold", 0, 32'h0, 1'b1, 1, 0);
        step();
        #2 rst = 1'b1;
        step(); rd(0, 5, 1'b1); rd(1, 3, 1'b1);
        push_exp("midrst_r5", 0, 32'h0, 1'b1, 1, 0);
        push_exp("midrst_r3", 1, 32'h0, 1'b1, 0, 0);

        step();
        step();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
